// File: rtl/i2c_simple_target_if.sv
// Bus-side and status signals of the receive-only two-wire target.
// The master modport is the pad/bench side; the slave modport is the target.
interface i2c_simple_target_if #(
    parameter int MAX_BYTES = 8
);
    logic       scl_in;
    logic       sda_in;
    logic       sda_out_en;
    logic [7:0] rx_data [0:MAX_BYTES-1];
    logic [3:0] rx_count;
    logic       addr_match;
    logic       overflow;
    logic       busy;
    logic       frame_done;

    modport master (
        output scl_in, sda_in,
        input  sda_out_en, rx_data, rx_count, addr_match, overflow, busy, frame_done
    );

    modport slave (
        input  scl_in, sda_in,
        output sda_out_en, rx_data, rx_count, addr_match, overflow, busy, frame_done
    );
endinterface

// File: rtl/i2c_simple_target.sv
// Receive-only two-wire bus target: synchronises SCL/SDA, detects START/STOP,
// shifts bytes in LSB-first, checks an optional address byte, ACKs by pulling
// SDA low and buffers up to MAX_BYTES payload bytes.
module i2c_simple_target #(
    parameter logic [7:0] TARGET_ADDR = 8'h4E,
    parameter bit         ADDR_CHECK  = 1'b1,
    parameter int         MAX_BYTES   = 8
) (
    input  logic clk,
    input  logic rst,
    i2c_simple_target_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        RX_BYTE,
        ACK_SETUP,
        ACK_HOLD,
        IGNORE
    } state_t;

    // Synchroniser chain and history; all idle-high so reset release is silent.
    logic scl_s1_q, scl_s2_q, scl_hist_q;
    logic sda_s1_q, sda_s2_q, sda_hist_q;

    // Bus events, registered so the FSM sees them 3 clk after the pad edge.
    logic scl_rise_q, scl_rise_d;
    logic scl_fall_q, scl_fall_d;
    logic start_q, start_d;
    logic stop_q, stop_d;

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       first_q, first_d;
    logic [3:0] rx_count_q, rx_count_d;
    logic [7:0] rx_data_q [0:MAX_BYTES-1];
    logic [7:0] rx_data_d [0:MAX_BYTES-1];
    logic       addr_match_q, addr_match_d;
    logic       overflow_q, overflow_d;
    logic       sda_oe_q, sda_oe_d;
    logic       frame_done_q, frame_done_d;

    // Event decode from current (s2) and previous (hist) samples. An SDA change
    // in the same sample as an SCL change never qualifies as START/STOP because
    // SCL must be high in both samples.
    always_comb begin
        scl_rise_d = scl_s2_q & ~scl_hist_q;
        scl_fall_d = ~scl_s2_q & scl_hist_q;
        start_d    = scl_s2_q & scl_hist_q & ~sda_s2_q & sda_hist_q;
        stop_d     = scl_s2_q & scl_hist_q & sda_s2_q & ~sda_hist_q;
    end

    // Frame FSM next-state and datapath. STOP and START override every state.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        first_d      = first_q;
        rx_count_d   = rx_count_q;
        rx_data_d    = rx_data_q;
        addr_match_d = addr_match_q;
        overflow_d   = overflow_q;
        sda_oe_d     = sda_oe_q;
        frame_done_d = 1'b0;

        if (stop_q) begin
            state_d      = IDLE;
            sda_oe_d     = 1'b0;
            // A stray STOP on an idle bus must not re-announce the last frame.
            frame_done_d = addr_match_q && (state_q != IDLE);
        end else if (start_q) begin
            state_d      = RX_BYTE;
            bit_cnt_d    = 3'd0;
            first_d      = ADDR_CHECK;
            rx_count_d   = 4'd0;
            overflow_d   = 1'b0;
            addr_match_d = ~ADDR_CHECK;
            sda_oe_d     = 1'b0;
        end else begin
            case (state_q)
                RX_BYTE: begin
                    if (scl_rise_q) begin
                        shift_d[bit_cnt_q] = sda_hist_q;
                        bit_cnt_d          = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = ACK_SETUP;
                        end
                    end
                end
                ACK_SETUP: begin
                    // Decide at the end of the 8th data clock so SDA is only
                    // touched while SCL is low.
                    if (scl_fall_q) begin
                        if (ADDR_CHECK && first_q) begin
                            if (shift_q != TARGET_ADDR) begin
                                state_d = IGNORE;
                            end else begin
                                addr_match_d = 1'b1;
                                first_d      = 1'b0;
                                sda_oe_d     = 1'b1;
                                state_d      = ACK_HOLD;
                            end
                        end else if (int'(rx_count_q) < MAX_BYTES) begin
                            for (int i = 0; i < MAX_BYTES; i++) begin
                                if (int'(rx_count_q) == i) begin
                                    rx_data_d[i] = shift_q;
                                end
                            end
                            rx_count_d = rx_count_q + 4'd1;
                            sda_oe_d   = 1'b1;
                            state_d    = ACK_HOLD;
                        end else begin
                            overflow_d = 1'b1;
                            state_d    = IGNORE;
                        end
                    end
                end
                ACK_HOLD: begin
                    // Hold SDA low however long SCL stays high; release on fall.
                    if (scl_fall_q) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 3'd0;
                        state_d   = RX_BYTE;
                    end
                end
                IGNORE: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    // All state: synchronisers, event flags and the FSM registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_s1_q     <= 1'b1;
            scl_s2_q     <= 1'b1;
            scl_hist_q   <= 1'b1;
            sda_s1_q     <= 1'b1;
            sda_s2_q     <= 1'b1;
            sda_hist_q   <= 1'b1;
            scl_rise_q   <= 1'b0;
            scl_fall_q   <= 1'b0;
            start_q      <= 1'b0;
            stop_q       <= 1'b0;
            state_q      <= IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'd0;
            first_q      <= 1'b0;
            rx_count_q   <= 4'd0;
            for (int i = 0; i < MAX_BYTES; i++) begin
                rx_data_q[i] <= 8'd0;
            end
            addr_match_q <= 1'b0;
            overflow_q   <= 1'b0;
            sda_oe_q     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            scl_s1_q     <= bus.scl_in;
            scl_s2_q     <= scl_s1_q;
            scl_hist_q   <= scl_s2_q;
            sda_s1_q     <= bus.sda_in;
            sda_s2_q     <= sda_s1_q;
            sda_hist_q   <= sda_s2_q;
            scl_rise_q   <= scl_rise_d;
            scl_fall_q   <= scl_fall_d;
            start_q      <= start_d;
            stop_q       <= stop_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            first_q      <= first_d;
            rx_count_q   <= rx_count_d;
            rx_data_q    <= rx_data_d;
            addr_match_q <= addr_match_d;
            overflow_q   <= overflow_d;
            sda_oe_q     <= sda_oe_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.sda_out_en = sda_oe_q;
    assign bus.rx_data    = rx_data_q;
    assign bus.rx_count   = rx_count_q;
    assign bus.addr_match = addr_match_q;
    assign bus.overflow   = overflow_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_i2c_simple_target.sv
// Directed bench for i2c_simple_target: a bit-banged LSB-first master drives
// one of three targets (default, MAX_BYTES=2, ADDR_CHECK=0) over open-drain SDA.
module tb_i2c_simple_target;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    int   sel = 0;

    always #5 clk = ~clk;

    i2c_simple_target_if #(.MAX_BYTES(8)) bus0 ();
    i2c_simple_target_if #(.MAX_BYTES(2)) bus1 ();
    i2c_simple_target_if #(.MAX_BYTES(8)) bus2 ();

    i2c_simple_target #(.TARGET_ADDR(8'h4E), .ADDR_CHECK(1'b1), .MAX_BYTES(8))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    i2c_simple_target #(.TARGET_ADDR(8'h4E), .ADDR_CHECK(1'b1), .MAX_BYTES(2))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));
    i2c_simple_target #(.TARGET_ADDR(8'h4E), .ADDR_CHECK(1'b0), .MAX_BYTES(8))
        dut2 (.clk(clk), .rst(rst), .bus(bus2));

    // Only the selected target sees traffic; the others see an idle bus.
    assign bus0.scl_in = (sel == 0) ? scl_m : 1'b1;
    assign bus1.scl_in = (sel == 1) ? scl_m : 1'b1;
    assign bus2.scl_in = (sel == 2) ? scl_m : 1'b1;
    assign bus0.sda_in = (sel == 0) ? (sda_m & ~bus0.sda_out_en) : 1'b1;
    assign bus1.sda_in = (sel == 1) ? (sda_m & ~bus1.sda_out_en) : 1'b1;
    assign bus2.sda_in = (sel == 2) ? (sda_m & ~bus2.sda_out_en) : 1'b1;

    logic oe_sel, fd_sel;
    always_comb begin
        oe_sel = bus0.sda_out_en;
        fd_sel = bus0.frame_done;
        if (sel == 1) begin
            oe_sel = bus1.sda_out_en;
            fd_sel = bus1.frame_done;
        end else if (sel == 2) begin
            oe_sel = bus2.sda_out_en;
            fd_sel = bus2.frame_done;
        end
    end

    // Running counts of frame_done pulses and SDA-driven cycles per target.
    int fd_cnt0 = 0, fd_cnt1 = 0, fd_cnt2 = 0, oe_cnt0 = 0;
    always @(posedge clk) begin
        if (bus0.frame_done) fd_cnt0 <= fd_cnt0 + 1;
        if (bus1.frame_done) fd_cnt1 <= fd_cnt1 + 1;
        if (bus2.frame_done) fd_cnt2 <= fd_cnt2 + 1;
        if (bus0.sda_out_en) oe_cnt0 <= oe_cnt0 + 1;
    end

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] tx [0:7];
    int   acks;
    logic ack_error;
    logic lat_a3, lat_a4, rel3, rel4, oe_hi_end, fd3, fd4;

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        scl_m = 1'b1; sda_m = 1'b1;
        wait_clk(8);
        sda_m = 1'b0;
        wait_clk(8);
        scl_m = 1'b0;
    endtask

    task automatic bus_bit(input logic b);
        wait_clk(4);
        sda_m = b;
        wait_clk(4);
        scl_m = 1'b1;
        wait_clk(8);
        scl_m = 1'b0;
    endtask

    // Bit whose SDA change coincides with both SCL edges.
    task automatic bus_bit_sim(input logic b);
        wait_clk(8);
        scl_m = 1'b1; sda_m = b;
        wait_clk(8);
        scl_m = 1'b0; sda_m = ~b;
    endtask

    // ACK slot, entered right after the 8th SCL fall; hi_ext stretches SCL high.
    task automatic bus_ack(input int hi_ext, output logic ack);
        wait_clk(3); lat_a3 = oe_sel;
        wait_clk(1); lat_a4 = oe_sel;
        sda_m = 1'b1;
        wait_clk(4);
        scl_m = 1'b1;
        wait_clk(4);
        ack = ~(sda_m & ~oe_sel);
        wait_clk(4 + hi_ext);
        oe_hi_end = oe_sel;
        scl_m = 1'b0;
        wait_clk(3); rel3 = oe_sel;
        wait_clk(1); rel4 = oe_sel;
    endtask

    task automatic bus_stop();
        wait_clk(4);
        sda_m = 1'b0;
        wait_clk(4);
        scl_m = 1'b1;
        wait_clk(8);
        sda_m = 1'b1;
        wait_clk(3); fd3 = fd_sel;
        wait_clk(1); fd4 = fd_sel;
        wait_clk(8);
    endtask

    task automatic send_frame(input int s, input int n);
        logic a;
        sel = s;
        acks = 0;
        ack_error = 1'b0;
        bus_start();
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < 8; i++) bus_bit(tx[k][i]);
            bus_ack(0, a);
            if (a) acks++;
            else begin
                ack_error = 1'b1;
                break;
            end
        end
        bus_stop();
        $display("frame sel=%0d bytes=%0d acks=%0d ack_error=%0d", s, n, acks, ack_error);
    endtask

    task automatic test_reset();
        n_cmp++; if (bus0.sda_out_en !== 1'b0) begin n_err++; $display("FAIL reset_oe got=%b exp=0", bus0.sda_out_en); end
        n_cmp++; if (bus0.rx_count !== 4'd0) begin n_err++; $display("FAIL reset_rx_count got=%0d exp=0", bus0.rx_count); end
        n_cmp++; if (bus0.rx_data[0] !== 8'h00) begin n_err++; $display("FAIL reset_rx_data got=%h exp=00", bus0.rx_data[0]); end
        n_cmp++; if (bus0.addr_match !== 1'b0) begin n_err++; $display("FAIL reset_addr_match got=%b exp=0", bus0.addr_match); end
        n_cmp++; if (bus0.overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got=%b exp=0", bus0.overflow); end
        n_cmp++; if (bus0.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", bus0.busy); end
        n_cmp++; if (bus0.frame_done !== 1'b0) begin n_err++; $display("FAIL reset_frame_done got=%b exp=0", bus0.frame_done); end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        int fd0;
        fd0 = fd_cnt0;
        tx[0] = 8'h4E; tx[1] = 8'hA5; tx[2] = 8'h3C;
        send_frame(0, 3);
        n_cmp++; if (acks !== 3) begin n_err++; $display("FAIL basic_acks got=%0d exp=3", acks); end
        n_cmp++; if (ack_error !== 1'b0) begin n_err++; $display("FAIL basic_ack_error got=%b exp=0", ack_error); end
        n_cmp++; if (bus0.rx_count !== 4'd2) begin n_err++; $display("FAIL basic_rx_count got=%0d exp=2", bus0.rx_count); end
        n_cmp++; if (bus0.rx_data[0] !== 8'hA5) begin n_err++; $display("FAIL basic_rx_data0 got=%h exp=a5", bus0.rx_data[0]); end
        n_cmp++; if (bus0.rx_data[1] !== 8'h3C) begin n_err++; $display("FAIL basic_rx_data1 got=%h exp=3c", bus0.rx_data[1]); end
        n_cmp++; if (bus0.addr_match !== 1'b1) begin n_err++; $display("FAIL basic_addr_match got=%b exp=1", bus0.addr_match); end
        n_cmp++; if (bus0.overflow !== 1'b0) begin n_err++; $display("FAIL basic_overflow got=%b exp=0", bus0.overflow); end
        n_cmp++; if (bus0.busy !== 1'b0) begin n_err++; $display("FAIL basic_busy got=%b exp=0", bus0.busy); end
        n_cmp++; if (fd_cnt0 - fd0 !== 1) begin n_err++; $display("FAIL basic_frame_done_count got=%0d exp=1", fd_cnt0 - fd0); end
        n_cmp++; if ({lat_a3, lat_a4} !== 2'b01) begin n_err++; $display("FAIL basic_ack_assert_latency got=%b exp=01", {lat_a3, lat_a4}); end
        n_cmp++; if ({rel3, rel4} !== 2'b10) begin n_err++; $display("FAIL basic_ack_release_latency got=%b exp=10", {rel3, rel4}); end
        n_cmp++; if ({fd3, fd4} !== 2'b01) begin n_err++; $display("FAIL basic_frame_done_latency got=%b exp=01", {fd3, fd4}); end
    endtask

    task automatic test_bad_addr();
        int fd0, oe0;
        fd0 = fd_cnt0; oe0 = oe_cnt0;
        tx[0] = 8'h4C; tx[1] = 8'h11;
        send_frame(0, 2);
        n_cmp++; if (ack_error !== 1'b1) begin n_err++; $display("FAIL badaddr_ack_error got=%b exp=1", ack_error); end
        n_cmp++; if (bus0.addr_match !== 1'b0) begin n_err++; $display("FAIL badaddr_addr_match got=%b exp=0", bus0.addr_match); end
        n_cmp++; if (bus0.rx_count !== 4'd0) begin n_err++; $display("FAIL badaddr_rx_count got=%0d exp=0", bus0.rx_count); end
        n_cmp++; if (fd_cnt0 - fd0 !== 0) begin n_err++; $display("FAIL badaddr_frame_done_count got=%0d exp=0", fd_cnt0 - fd0); end
        n_cmp++; if (oe_cnt0 - oe0 !== 0) begin n_err++; $display("FAIL badaddr_oe_cycles got=%0d exp=0", oe_cnt0 - oe0); end
        n_cmp++; if (bus0.busy !== 1'b0) begin n_err++; $display("FAIL badaddr_busy got=%b exp=0", bus0.busy); end
    endtask

    task automatic test_overflow();
        int fd0;
        fd0 = fd_cnt1;
        tx[0] = 8'h4E; tx[1] = 8'h01; tx[2] = 8'h02; tx[3] = 8'h03;
        send_frame(1, 4);
        n_cmp++; if (acks !== 3) begin n_err++; $display("FAIL ovf_acks got=%0d exp=3", acks); end
        n_cmp++; if (ack_error !== 1'b1) begin n_err++; $display("FAIL ovf_ack_error got=%b exp=1", ack_error); end
        n_cmp++; if (bus1.overflow !== 1'b1) begin n_err++; $display("FAIL ovf_overflow got=%b exp=1", bus1.overflow); end
        n_cmp++; if (bus1.rx_count !== 4'd2) begin n_err++; $display("FAIL ovf_rx_count got=%0d exp=2", bus1.rx_count); end
        n_cmp++; if (bus1.rx_data[0] !== 8'h01) begin n_err++; $display("FAIL ovf_rx_data0 got=%h exp=01", bus1.rx_data[0]); end
        n_cmp++; if (bus1.rx_data[1] !== 8'h02) begin n_err++; $display("FAIL ovf_rx_data1 got=%h exp=02", bus1.rx_data[1]); end
        n_cmp++; if (fd_cnt1 - fd0 !== 1) begin n_err++; $display("FAIL ovf_frame_done_count got=%0d exp=1", fd_cnt1 - fd0); end
    endtask

    task automatic test_no_addr();
        int fd0;
        fd0 = fd_cnt2;
        tx[0] = 8'h80; tx[1] = 8'h7F;
        send_frame(2, 2);
        n_cmp++; if (acks !== 2) begin n_err++; $display("FAIL noaddr_acks got=%0d exp=2", acks); end
        n_cmp++; if (bus2.rx_count !== 4'd2) begin n_err++; $display("FAIL noaddr_rx_count got=%0d exp=2", bus2.rx_count); end
        n_cmp++; if (bus2.rx_data[0] !== 8'h80) begin n_err++; $display("FAIL noaddr_rx_data0 got=%h exp=80", bus2.rx_data[0]); end
        n_cmp++; if (bus2.rx_data[1] !== 8'h7F) begin n_err++; $display("FAIL noaddr_rx_data1 got=%h exp=7f", bus2.rx_data[1]); end
        n_cmp++; if (bus2.addr_match !== 1'b1) begin n_err++; $display("FAIL noaddr_addr_match got=%b exp=1", bus2.addr_match); end
        n_cmp++; if (fd_cnt2 - fd0 !== 1) begin n_err++; $display("FAIL noaddr_frame_done_count got=%0d exp=1", fd_cnt2 - fd0); end
    endtask

    task automatic test_reset_mid_frame();
        int fd0;
        logic [7:0] addr;
        addr = 8'h4E;
        sel = 0;
        bus_start();
        for (int i = 0; i < 8; i++) bus_bit(addr[i]);
        wait_clk(4);
        n_cmp++; if (bus0.sda_out_en !== 1'b1) begin n_err++; $display("FAIL rstmid_oe_before got=%b exp=1", bus0.sda_out_en); end
        #3 rst = 1'b1;
        #1;
        n_cmp++; if (bus0.sda_out_en !== 1'b0) begin n_err++; $display("FAIL rstmid_oe_async got=%b exp=0", bus0.sda_out_en); end
        n_cmp++; if (bus0.busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got=%b exp=0", bus0.busy); end
        n_cmp++; if (bus0.rx_data[0] !== 8'h00) begin n_err++; $display("FAIL rstmid_rx_data_clear got=%h exp=00", bus0.rx_data[0]); end
        scl_m = 1'b1; sda_m = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(4);
        $display("reset pulse applied mid-frame");
        fd0 = fd_cnt0;
        tx[0] = 8'h4E; tx[1] = 8'hA5;
        send_frame(0, 2);
        n_cmp++; if (acks !== 2) begin n_err++; $display("FAIL rstmid_acks got=%0d exp=2", acks); end
        n_cmp++; if (bus0.rx_count !== 4'd1) begin n_err++; $display("FAIL rstmid_rx_count got=%0d exp=1", bus0.rx_count); end
        n_cmp++; if (bus0.rx_data[0] !== 8'hA5) begin n_err++; $display("FAIL rstmid_rx_data0 got=%h exp=a5", bus0.rx_data[0]); end
        n_cmp++; if (fd_cnt0 - fd0 !== 1) begin n_err++; $display("FAIL rstmid_frame_done_count got=%0d exp=1", fd_cnt0 - fd0); end
    endtask

    task automatic test_same_sample_and_stretch();
        int fd0, n_ack;
        logic a;
        logic [7:0] addr, data;
        addr = 8'h4E; data = 8'h5A;
        sel = 0;
        n_ack = 0;
        fd0 = fd_cnt0;
        bus_start();
        for (int i = 0; i < 8; i++) bus_bit(addr[i]);
        bus_ack(8, a);
        if (a) n_ack++;
        n_cmp++; if (oe_hi_end !== 1'b1) begin n_err++; $display("FAIL stretch_oe_held got=%b exp=1", oe_hi_end); end
        for (int i = 0; i < 8; i++) bus_bit_sim(data[i]);
        bus_ack(0, a);
        if (a) n_ack++;
        n_cmp++; if (n_ack !== 2) begin n_err++; $display("FAIL glitch_acks got=%0d exp=2", n_ack); end
        n_cmp++; if (bus0.busy !== 1'b1) begin n_err++; $display("FAIL glitch_busy got=%b exp=1", bus0.busy); end
        n_cmp++; if (fd_cnt0 - fd0 !== 0) begin n_err++; $display("FAIL glitch_frame_done_mid got=%0d exp=0", fd_cnt0 - fd0); end
        n_cmp++; if (bus0.rx_count !== 4'd1) begin n_err++; $display("FAIL glitch_rx_count got=%0d exp=1", bus0.rx_count); end
        n_cmp++; if (bus0.rx_data[0] !== 8'h5A) begin n_err++; $display("FAIL glitch_rx_data0 got=%h exp=5a", bus0.rx_data[0]); end
        bus_stop();
        $display("frame sel=0 same-sample/stretched frame acks=%0d", n_ack);
        n_cmp++; if (bus0.busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy_after_stop got=%b exp=0", bus0.busy); end
    endtask

    initial begin
        wait_clk(3);
        rst = 1'b0;
        wait_clk(4);
        test_reset();
        test_basic();
        test_bad_addr();
        test_overflow();
        test_no_addr();
        test_reset_mid_frame();
        test_same_sample_and_stretch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
